inv_sub_bytes: RTL and testbench



---
 rtl/inv_sub_bytes.sv | 127 ++++++++++++
 tb/tb_inv_sub_bytes.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes.sv
`timescale 1ns/1ps
// AES InvSubBytes over a 128-bit state, one byte per cycle through a registered-address
// 256-entry inverse S-box ROM, with valid/ready handshakes on both sides.
module inv_sub_bytes (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Element 0 is the first byte listed, so the table indexes directly by input byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  state_t       r_state;
  state_t       w_state_next;
  logic [4:0]   r_cnt;
  logic [127:0] r_src;
  logic [7:0]   r_rom_addr;
  logic [7:0]   w_rom_data;
  logic [7:0]   w_src_bytes [16];
  logic [7:0]   r_out_bytes [16];
  logic [4:0]   w_wr_idx;
  logic         w_accept;
  logic         w_issue;
  logic         w_write;

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_issue   = (r_state == RUN) && !r_cnt[4];
  assign w_write   = (r_state == RUN) && (r_cnt != 5'd0);
  assign w_wr_idx  = r_cnt - 5'd1;
  assign w_rom_data = INV_SBOX[r_rom_addr];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = RUN;
      RUN:     if (r_cnt == 5'd16) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
    end else if (w_accept) begin
      r_cnt <= 5'd0;
    end else if ((r_state == RUN) && (r_cnt != 5'd16)) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= '0;
    end else if (w_accept) begin
      r_src <= in_data;
    end
  end

  // The ROM address register is the lookup's pipeline stage: data for byte cnt is
  // consumed one cycle later, when cnt has advanced to cnt+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_addr <= 8'd0;
    end else if (w_issue) begin
      r_rom_addr <= w_src_bytes[r_cnt[3:0]];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      assign w_src_bytes[gi] = r_src[127 - 8*gi -: 8];
      assign out_data[127 - 8*gi -: 8] = r_out_bytes[gi];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_bytes[gi] <= 8'd0;
        end else if (w_write && (w_wr_idx == 5'(gi))) begin
          r_out_bytes[gi] <= w_rom_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_inv_sub_bytes.sv
`timescale 1ns/1ps
// Self-checking bench for inv_sub_bytes; the reference inverse S-box is derived from
// GF(2^8) inversion plus the AES affine map, then inverted as a table.
module tb_inv_sub_bytes;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];
  logic [7:0] inv_tab  [256];

  inv_sub_bytes dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'd0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] v);
    logic [7:0] inv = 8'd1;
    logic [7:0] s;
    logic [7:0] r;
    for (int k = 0; k < 254; k++) inv = gf_mul(inv, v);
    s = inv;
    r = inv;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tab[d[127 - 8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one block from an IDLE start; entry and exit are 1 time unit after a rising edge.
  task automatic do_block(input logic [127:0] d, input bit wiggle, input bit ack,
                          output int lat, output int busy_n, output logic [127:0] res);
    int guard = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat    = -1;
    busy_n = 0;
    for (int c = 1; c <= 40; c++) begin
      if (wiggle) in_data = rand128();
      @(posedge clk); #1;
      if (busy) busy_n++;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    res = out_data;
    if (ack) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = rand128();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got in_ready/out_valid/busy=%b expected 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (out_data !== 128'd0) begin
      errors++;
      $display("FAIL reset_out_data: got %h expected 0", out_data);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
  endtask

  task automatic test_fips_vector();
    int lat, bn;
    logic [127:0] res;
    do_block(128'h63cab7040953d051cd60e0e7ba70e18c, 1'b0, 1'b1, lat, bn, res);
    checks++;
    if (lat != 17) begin
      errors++;
      $display("FAIL fips_latency: got %0d expected 17", lat);
    end
    checks++;
    if (bn != 16) begin
      errors++;
      $display("FAIL fips_busy_cycles: got %0d expected 16", bn);
    end
    checks++;
    if (res !== 128'h00102030405060708090a0b0c0d0e0f0) begin
      errors++;
      $display("FAIL fips_data: got %h expected 00102030405060708090a0b0c0d0e0f0", res);
    end
    $display("fips block: in=63cab7040953d051cd60e0e7ba70e18c out=%h lat=%0d", res, lat);
  endtask

  task automatic test_exhaustive();
    logic [7:0] perm [256];
    logic [7:0] t;
    logic [127:0] d, res, exp;
    logic [7:0] ib, ob;
    int lat, bn, j, rt_bad;
    for (int i = 0; i < 256; i++) perm[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) d[127 - 8*i -: 8] = perm[16*b + i];
      do_block(d, 1'b0, 1'b1, lat, bn, res);
      exp = model_block(d);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL exhaustive_block%0d: got %h expected %h", b, res, exp);
      end
      rt_bad = 0;
      for (int i = 0; i < 16; i++) begin
        ib = d[127 - 8*i -: 8];
        ob = res[127 - 8*i -: 8];
        if (sbox_tab[ob] !== ib) rt_bad++;
        if (ib == 8'hfe || ib == 8'h00 || ib == 8'h63) begin
          checks++;
          if ((ib == 8'hfe && ob !== 8'h0c) || (ib == 8'h00 && ob !== 8'h52) ||
              (ib == 8'h63 && ob !== 8'h00)) begin
            errors++;
            $display("FAIL spot_%h: got %h", ib, ob);
          end
        end
      end
      checks++;
      if (rt_bad != 0) begin
        errors++;
        $display("FAIL roundtrip_block%0d: got %0d bad bytes expected 0", b, rt_bad);
      end
      $display("exhaustive block %0d: in=%h out=%h lat=%0d", b, d, res, lat);
    end
  endtask

  task automatic test_backpressure();
    int lat, bn;
    logic [127:0] d, res, exp;
    d = rand128();
    exp = model_block(d);
    do_block(d, 1'b0, 1'b0, lat, bn, res);
    checks++;
    if (lat != 17 || res !== exp) begin
      errors++;
      $display("FAIL bp_result: got lat=%0d data=%h expected 17 %h", lat, res, exp);
    end
    in_valid = 1'b1;
    in_data  = rand128();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got ov=%b ir=%b busy=%b data=%h expected 1 0 0 %h",
                 c, out_valid, in_ready, busy, out_data, exp);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
    $display("backpressure block: in=%h out=%h", d, res);
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, od;
    logic [127:0] res [2];
    int acc_e [2];
    int out_e [2];
    int n_acc = 0;
    int n_out = 0;
    bit acc, oh;
    a = rand128();
    b = rand128();
    in_data = a; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 60 && n_out < 2; e++) begin
      acc = in_valid && in_ready;
      oh  = out_valid && out_ready;
      od  = out_data;
      @(posedge clk); #1;
      if (acc && n_acc < 2) begin
        acc_e[n_acc] = e;
        n_acc++;
        if (n_acc == 1) in_data = b;
        else in_valid = 1'b0;
      end
      if (oh && n_out < 2) begin
        out_e[n_out] = e;
        res[n_out] = od;
        n_out++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (n_acc != 2 || n_out != 2) begin
      errors++;
      $display("FAIL b2b_counts: got acc=%0d out=%0d expected 2 2", n_acc, n_out);
    end else begin
      checks++;
      if (out_e[0] - acc_e[0] != 18 || acc_e[1] - out_e[0] != 1) begin
        errors++;
        $display("FAIL b2b_timing: got out1-acc1=%0d acc2-out1=%0d expected 18 1",
                 out_e[0] - acc_e[0], acc_e[1] - out_e[0]);
      end
      checks++;
      if (res[0] !== model_block(a) || res[1] !== model_block(b)) begin
        errors++;
        $display("FAIL b2b_data: got %h %h expected %h %h", res[0], res[1], model_block(a), model_block(b));
      end
      $display("back-to-back: out1=%h out2=%h accept gap=%0d", res[0], res[1], acc_e[1] - out_e[0]);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bn;
    logic [127:0] res;
    in_data = rand128(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || out_data !== 128'd0) begin
      errors++;
      $display("FAIL midrun_reset: got ov/busy/ir=%b data=%h expected 001 0",
               {out_valid, busy, in_ready}, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_block({16{8'h16}}, 1'b0, 1'b1, lat, bn, res);
    checks++;
    if (res !== {16{8'hff}} || lat != 17) begin
      errors++;
      $display("FAIL after_reset_block: got %h lat=%0d expected all ff lat=17", res, lat);
    end
    $display("post-reset block: out=%h lat=%0d", res, lat);
  endtask

  task automatic test_input_hold();
    int lat, bn;
    logic [127:0] d, res, exp;
    d = rand128();
    exp = model_block(d);
    do_block(d, 1'b1, 1'b1, lat, bn, res);
    checks++;
    if (res !== exp) begin
      errors++;
      $display("FAIL input_hold: got %h expected %h", res, exp);
    end
    $display("input-hold block: in=%h out=%h", d, res);
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      sbox_tab[x] = fwd_sbox(8'(x));
      inv_tab[sbox_tab[x]] = 8'(x);
    end
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0; rst_n = 1'b0;
    test_reset();
    test_fips_vector();
    test_exhaustive();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_input_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
